button_bank: RTL and testbench

Parametrised debounced push-button bank with press, release and long-press event detection and per-channel LED drive. Generalises the two-button/four-LED demo to N channels, selectable input polarity and two LED modes. It sits between the board button pins and user logic (or PMOD LED pins) in the chip top level, clocked from the 100 MHz board clock.

---
 rtl/button_bank.sv | 135 +++++++++++++
 tb/tb_button_bank.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// button_bank: N-channel debounced push-button bank.
// Each channel synchronises its pin, normalises polarity, debounces the level
// and derives press / release / long-press pulses plus an LED drive.
// The release pulse output is called `released` because `release` is a
// reserved word in SystemVerilog.
module button_bank #(
  parameter int N               = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter int ACTIVE_LOW      = 1,
  parameter int LED_MODE        = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] button,
  input  logic         clear,
  output logic [N-1:0] state,
  output logic [N-1:0] press,
  output logic [N-1:0] released,
  output logic [N-1:0] long_press,
  output logic         any_event,
  output logic [N-1:0] led
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  // Debounce counter value on the last cycle of the acceptance window.
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  // Hold counter value that fires the long-press pulse, and its saturation value.
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  // Synchroniser idles at the released pin level so reset never looks like a press.
  localparam logic [1:0]    SYNC_IDLE = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic [1:0]    sync_reg;
    logic          s;
    logic [DW-1:0] db_cnt_reg, db_cnt_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic          state_reg, state_next;
    logic          press_reg, press_next;
    logic          rel_reg, rel_next;
    logic          long_reg, long_next;

    // Normalised synchronised level, 1 = pressed.
    assign s = (ACTIVE_LOW != 0) ? ~sync_reg[1] : sync_reg[1];

    // Debounce window and hold timer next-state logic.
    always_comb begin
      db_cnt_next   = '0;
      hold_cnt_next = hold_cnt_reg;
      state_next    = state_reg;
      press_next    = 1'b0;
      rel_next      = 1'b0;
      long_next     = 1'b0;

      // Any cycle of agreement leaves the counter at zero, restarting the window.
      if (s != state_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          state_next = s;
          press_next = s;
          rel_next   = ~s;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end

      // Saturating at LONG_CYCLES keeps the fire value from recurring while held.
      if (press_next || !state_reg) begin
        hold_cnt_next = '0;
      end else if (hold_cnt_reg != HOLD_MAX) begin
        hold_cnt_next = hold_cnt_reg + 1'b1;
      end

      // Uses the current level, so a release on the same edge does not suppress it.
      long_next = state_reg && (hold_cnt_reg == HOLD_FIRE);
    end

    // Per-channel registers: synchroniser, counters, level and event pulses.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_reg     <= SYNC_IDLE;
        db_cnt_reg   <= '0;
        hold_cnt_reg <= '0;
        state_reg    <= 1'b0;
        press_reg    <= 1'b0;
        rel_reg      <= 1'b0;
        long_reg     <= 1'b0;
      end else begin
        sync_reg     <= {sync_reg[0], button[gi]};
        db_cnt_reg   <= db_cnt_next;
        hold_cnt_reg <= hold_cnt_next;
        state_reg    <= state_next;
        press_reg    <= press_next;
        rel_reg      <= rel_next;
        long_reg     <= long_next;
      end
    end

    assign state[gi]      = state_reg;
    assign press[gi]      = press_reg;
    assign released[gi]   = rel_reg;
    assign long_press[gi] = long_reg;

    if (LED_MODE == 0) begin : g_led_follow
      assign led[gi] = state_reg;
    end else begin : g_led_toggle
      logic led_reg;

      // Toggle latch flipped by each press; clear wins over a coincident press.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          led_reg <= 1'b0;
        end else if (clear) begin
          led_reg <= 1'b0;
        end else if (press_reg) begin
          led_reg <= ~led_reg;
        end
      end

      assign led[gi] = led_reg;
    end
  end

  // Registered summary of every event pulse across all channels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_event <= 1'b0;
    end else begin
      any_event <= |{press, released, long_press};
    end
  end

endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: randomised button stimulus, window-based reference model
// feeding an expected-event queue, and an independent monitor that compares.
`timescale 1ns/1ps
module tb_button_bank;

  localparam int N          = 2;
  localparam int DB         = 4;
  localparam int LONG       = 20;
  localparam int ACTIVE_LOW = 1;
  localparam int LED_MODE   = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear = 1'b0;
  logic [N-1:0] button = '0;
  logic [N-1:0] state, press, released, long_press, led;
  logic         any_event;

  always #5 clk = ~clk;

  button_bank #(
    .N(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG),
    .ACTIVE_LOW(ACTIVE_LOW), .LED_MODE(LED_MODE)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .clear(clear),
    .state(state), .press(press), .released(released),
    .long_press(long_press), .any_event(any_event), .led(led)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
    logic [N-1:0] st;
    logic [N-1:0] led;
    logic         any;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  cyc = 0;

  // Reference model state: pin pipeline, last DB samples, outputs, press time.
  logic [N-1:0]  m_sync1, m_sync2, m_state, m_press, m_rel, m_lng, m_led;
  logic          m_any;
  logic [DB-1:0] m_win [N];
  int            m_press_cyc [N];

  task automatic model_reset();
    m_sync1 = (ACTIVE_LOW != 0) ? '1 : '0;
    m_sync2 = (ACTIVE_LOW != 0) ? '1 : '0;
    m_state = '0; m_press = '0; m_rel = '0; m_lng = '0; m_led = '0; m_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_win[i]       = '0;
      m_press_cyc[i] = -100000;
    end
  endtask

  // Reference model: a level is accepted once the last DB samples all disagree
  // with it; long press is LONG edges after the press edge while still held.
  always @(posedge clk) begin : model_step
    logic [N-1:0] n_state, n_press, n_rel, n_lng, n_led;
    logic         n_any;
    logic         s_now;
    ev_t          e;
    cyc++;
    if (!rst) begin
      model_reset();
      exp_q.delete();
    end else begin
      n_any = |{m_press, m_rel, m_lng};
      for (int i = 0; i < N; i++) begin
        s_now    = (ACTIVE_LOW != 0) ? ~m_sync2[i] : m_sync2[i];
        m_win[i] = {m_win[i][DB-2:0], s_now};
        n_state[i] = m_state[i];
        n_press[i] = 1'b0;
        n_rel[i]   = 1'b0;
        if (m_win[i] == {DB{~m_state[i]}}) begin
          n_state[i] = ~m_state[i];
          n_press[i] = ~m_state[i];
          n_rel[i]   = m_state[i];
        end
        n_lng[i] = m_state[i] && ((cyc - m_press_cyc[i]) == LONG);
        if (n_press[i]) m_press_cyc[i] = cyc;
        if (LED_MODE == 0) n_led[i] = n_state[i];
        else n_led[i] = clear ? 1'b0 : (m_press[i] ? ~m_led[i] : m_led[i]);
      end
      m_sync2 = m_sync1;
      m_sync1 = button;
      m_state = n_state; m_press = n_press; m_rel = n_rel;
      m_lng = n_lng; m_led = n_led; m_any = n_any;
      if ((|n_press) || (|n_rel) || (|n_lng) || n_any) begin
        e.cyc = cyc; e.press = n_press; e.rel = n_rel; e.lng = n_lng;
        e.st = n_state; e.led = n_led; e.any = n_any;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: whenever the DUT shows an event, pop and compare the expected one.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        $display("FAIL missing_event cyc=%0d: DUT showed no event, required press=%b release=%b long=%b any=%b",
                 e.cyc, e.press, e.rel, e.lng, e.any);
      end
      if ((|press) || (|released) || (|long_press) || any_event) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          $display("FAIL unexpected_event cyc=%0d: got press=%b release=%b long=%b any=%b, required none",
                   cyc, press, released, long_press, any_event);
        end else begin
          e = exp_q.pop_front();
          if (press === e.press && released === e.rel && long_press === e.lng &&
              any_event === e.any && state === e.st && led === e.led) begin
            passes++;
          end else begin
            $display("FAIL event cyc=%0d: got p=%b r=%b l=%b a=%b s=%b led=%b, required p=%b r=%b l=%b a=%b s=%b led=%b",
                     cyc, press, released, long_press, any_event, state, led,
                     e.press, e.rel, e.lng, e.any, e.st, e.led);
          end
        end
      end
    end
  end

  task automatic check_idle(input string name);
    checks++;
    if (state === '0 && press === '0 && released === '0 && long_press === '0 &&
        any_event === 1'b0 && led === '0) begin
      passes++;
    end else begin
      $display("FAIL %s: got s=%b p=%b r=%b l=%b a=%b led=%b, required all 0",
               name, state, press, released, long_press, any_event, led);
    end
  endtask

  bit lvl [N];
  int rem [N];

  initial begin
    // Buttons held pressed (pins low) through reset.
    rst = 1'b0; clear = 1'b0; button = '0;
    for (int i = 0; i < N; i++) begin
      lvl[i] = 1'b1;
      rem[i] = 30;
    end
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b1;
    @(negedge clk);
    #1 check_idle("reset_release_idle");

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          int r;
          lvl[i] = ~lvl[i];
          r = $urandom_range(0, 9);
          if (r < 3)       rem[i] = $urandom_range(1, 3);
          else if (r < 7)  rem[i] = $urandom_range(5, 15);
          else if (r < 9)  rem[i] = $urandom_range(LONG + 1, 40);
          else             rem[i] = $urandom_range(LONG - 1, LONG + 1);
        end
        rem[i]--;
        button[i] = (ACTIVE_LOW != 0) ? ~lvl[i] : lvl[i];
      end
      // Aim clear at press cycles often to exercise the clear/press collision.
      clear = (|m_press) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      if ((c % 900) == 450 || (c % 900) == 700) begin
        #2 rst = 1'b0;
        #1 check_idle("async_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
      end
    end

    clear = 1'b0;
    button = (ACTIVE_LOW != 0) ? '1 : '0;
    repeat (LONG + 20) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL drain: got %0d expected events never shown, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
